// File: rtl/ysyx_24100006_dmem_resp.sv
// Data-memory responder: accepts one load/store, waits LATENCY edges,
// then does a byte-masked word access and returns data or an error.
//   req_*  : valid/ready request channel from the LSU
//   rsp_*  : valid/ready response channel (rdata, err)
module ysyx_24100006_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_n;

  logic [3:0]  cnt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic          in_range;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          unused_bits;

  assign accept = (state == IDLE) && req_valid;
  assign access = (state == WAIT) && (cnt == 4'd0);

  // 33-bit compare so BASE+size may reach 2^32
  assign in_range = ({1'b0, addr_q} >= {1'b0, BASE_ADDR})
                 && ({1'b0, addr_q} < LIMIT);
  assign off = addr_q - BASE_ADDR;
  assign idx = off[AW+1:2];

  assign unused_bits = ^{off[1:0], off[31:AW+2],
                         req_wmask[7:4], req_addr[1:0]};

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_valid) state_n = WAIT;
      WAIT: if (cnt == 4'd0) state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= {req_addr[31:2], 2'b00};
        wdata_q <= req_wdata;
        wmask_q <= req_wmask[3:0];
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rdata_q <= (!wen_q && in_range) ? mem[idx] : 32'd0;
        err_q   <= !in_range;
      end
    end
  end

  // array is not reset; reset forces IDLE so no write can occur then
  always_ff @(posedge clk) begin
    if (access && wen_q && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_dmem_resp.sv
// Bench for ysyx_24100006_dmem_resp: three builds (LATENCY 2, 1, 15)
// driven by directed and random transactions against a word-map model.
module tb_ysyx_24100006_dmem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int D0 = 1024;
  localparam int DS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_wen;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0][7:0]  req_wmask;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic [2:0][31:0] rsp_rdata;
  logic [2:0]       rsp_err;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_24100006_dmem_resp #(
      .DEPTH_WORDS(g == 0 ? D0 : DS),
      .BASE_ADDR  (BASE),
      .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wen  (req_wen[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  int total = 0;
  int bad = 0;
  logic [31:0] mdl [int];

  function automatic int lat_of(int k);
    return k == 0 ? 2 : (k == 1 ? 1 : 15);
  endfunction

  function automatic int depth_of(int k);
    return k == 0 ? D0 : DS;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: sparse word map keyed by dut*65536+word
  function automatic void model(input int k, input bit wen,
                                input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [7:0] wmask,
                                output logic [31:0] er,
                                output logic ee);
    longint a;
    longint lo;
    longint hi;
    int key;
    logic [31:0] w;
    a  = {32'd0, addr};
    lo = {32'd0, BASE};
    hi = lo + 4 * depth_of(k);
    er = 32'd0;
    ee = 1'b0;
    if (a < lo || a >= hi) begin
      ee = 1'b1;
      return;
    end
    key = k * 65536 + int'((a - lo) / 4);
    w = mdl.exists(key) ? mdl[key] : 32'd0;
    if (wen) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
      mdl[key] = w;
    end else begin
      er = w;
    end
  endfunction

  task automatic issue(int k, bit wen, logic [31:0] addr,
                       logic [31:0] wdata, logic [7:0] wmask);
    int n;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_wait", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    step();
    req_valid[k] = 1'b0;
    req_wen[k]   = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_wmask[k] = 8'($urandom);
    chk("busy_after_accept", 32'(req_ready[k]), 32'd0);
  endtask

  task automatic wait_rsp(int k, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (rsp_valid[k] !== 1'b1 && n < 40);
  endtask

  task automatic txn(int k, bit wen, logic [31:0] addr,
                     logic [31:0] wdata, logic [7:0] wmask,
                     output logic [31:0] got);
    logic [31:0] er;
    logic ee;
    int n;
    model(k, wen, addr, wdata, wmask, er, ee);
    rsp_ready[k] = 1'b1;
    issue(k, wen, addr, wdata, wmask);
    wait_rsp(k, n);
    chk("latency", 32'(n), 32'(lat_of(k)));
    got = rsp_rdata[k];
    chk("rdata", rsp_rdata[k], er);
    chk("err", 32'(rsp_err[k]), 32'(ee));
    step();
    chk("idle_after_rsp", {30'd0, rsp_valid[k], req_ready[k]}, 32'd1);
  endtask

  task automatic thr(int k, logic [31:0] addr);
    int first;
    int second;
    int third;
    first = -1;
    second = -1;
    third = -1;
    rsp_ready[k] = 1'b1;
    req_valid[k] = 1'b1;
    req_wen[k]   = 1'b0;
    req_addr[k]  = addr;
    req_wmask[k] = 8'd0;
    for (int c = 0; c < 60; c++) begin
      if (req_ready[k]) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
        else begin
          third = c;
          break;
        end
      end
      step();
    end
    req_valid[k] = 1'b0;
    chk("period_a", 32'(second - first), 32'(lat_of(k) + 2));
    chk("period_b", 32'(third - second), 32'(lat_of(k) + 2));
    step();
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] held;
    logic [31:0] a;
    int n;
    int r;
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = '1;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_req_ready", 32'(req_ready), 32'd7);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    for (int k = 0; k < 3; k++) chk("rst_rdata", rsp_rdata[k], 32'd0);
    rst_n = 1'b1;
    step();

    // preset words used later
    for (int i = 0; i < 8; i++)
      txn(0, 1'b1, BASE + 32'(i * 4), $urandom, 8'hFF, got);
    txn(0, 1'b1, BASE + 32'((D0 - 1) * 4), 32'hCAFE_F00D, 8'hFF, got);
    for (int i = 8; i < 17; i++)
      txn(0, 1'b1, BASE + 32'(i * 4), $urandom, 8'hFF, got);

    txn(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 8'h0F, got);
    chk("store_rdata_zero", got, 32'd0);
    txn(0, 1'b0, BASE + 32'h12, 32'd0, 8'h00, got);
    chk("load_deadbeef", got, 32'hDEAD_BEEF);

    txn(0, 1'b1, BASE + 32'h20, 32'h1122_3344, 8'h0F, got);
    txn(0, 1'b1, BASE + 32'h20, 32'h00AA_0000, 8'h04, got);
    txn(0, 1'b0, BASE + 32'h20, 32'd0, 8'h00, got);
    chk("byte_mask", got, 32'h11AA_3344);
    txn(0, 1'b1, BASE + 32'h22, 32'hBBCC_0000, 8'h0C, got);
    txn(0, 1'b0, BASE + 32'h20, 32'd0, 8'hF0, got);
    chk("half_mask", got, 32'hBBCC_3344);
    txn(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 8'hF0, got);
    txn(0, 1'b0, BASE + 32'h20, 32'd0, 8'h00, got);
    chk("zero_mask", got, 32'hBBCC_3344);

    // backpressure
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, BASE + 32'h10, 32'd0, 8'h00);
    wait_rsp(0, n);
    chk("bp_latency", 32'(n), 32'd2);
    held = rsp_rdata[0];
    chk("bp_rdata", held, 32'hDEAD_BEEF);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_addr[0]  = BASE + 32'h20;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_hold", rsp_rdata[0], held);
      chk("bp_no_accept", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    step();
    chk("bp_release", {30'd0, rsp_valid[0], req_ready[0]}, 32'd1);

    // out of range
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 8'h00, got);
    chk("oor_load_rdata", got, 32'd0);
    txn(0, 1'b1, BASE + 32'(D0 * 4), 32'h1234_5678, 8'h0F, got);
    txn(0, 1'b0, BASE + 32'((D0 - 1) * 4), 32'd0, 8'h00, got);
    chk("oor_last_word", got, 32'hCAFE_F00D);

    // reset while a store waits: word must stay unchanged
    issue(0, 1'b1, BASE + 32'h40, 32'h5555_AAAA, 8'h0F);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_ready", 32'(req_ready[0]), 32'd1);
    #3 rst_n = 1'b1;
    step();
    txn(0, 1'b0, BASE + 32'h40, 32'd0, 8'h00, got);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(9, 0);
      if (r < 8) a = BASE + 32'(r * 4);
      else if (r == 8) a = BASE + 32'((D0 - 1) * 4);
      else a = ($urandom_range(1, 0) == 0) ? BASE - 32'd4
                                           : BASE + 32'(D0 * 4);
      a[1:0] = 2'($urandom);
      txn(0, 1'($urandom), a, $urandom, 8'($urandom), got);
    end

    // short and long latency builds
    for (int k = 1; k < 3; k++) begin
      txn(k, 1'b1, BASE + 32'd4, $urandom, 8'hFF, got);
      txn(k, 1'b1, BASE + 32'd5, 32'h0000_7700, 8'h02, got);
      txn(k, 1'b0, BASE + 32'd4, 32'd0, 8'h00, got);
      txn(k, 1'b1, BASE + 32'(DS * 4), 32'h1, 8'h0F, got);
      txn(k, 1'b0, BASE + 32'((DS - 1) * 4) + 32'd4, 32'd0, 8'h0, got);
    end
    for (int k = 0; k < 3; k++) thr(k, BASE + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_dmem_resp.md
# ysyx_24100006_dmem_resp

Data-memory responder: the slave side of the LSU memory port. It accepts one load or store request at a time over a valid/ready handshake and holds it for a fixed, configurable latency. It then performs a word-aligned, byte-masked access to an internal word array and returns the read data (or a write acknowledge) over a valid/ready response channel. It replaces the zero-latency combinational memory behind MEMU and emulates SRAM/bus delay for pipeline stall testing.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: rising edges from request accept to response state entry (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored (aligned by the responder).
- req_wdata  in  32  store data, already lane-positioned.
- req_wmask  in  8  byte-lane mask, already shifted by the address offset; only [3:0] used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  full aligned word read (loads); 0 for stores and errors.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, accept the request and go to WAIT. Latch wen, aligned address, wdata, wmask[3:0]; load cnt=LATENCY-1.
  - WAIT: if cnt!=0, decrement cnt. If cnt==0, perform the access and go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE.
- Access, performed on the WAIT→RESP edge:
  - Index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
  - Store: write each byte i where wmask[i]=1; bytes with a mask bit of 0 are unchanged. rsp_rdata=0.
  - Load: rsp_rdata = the array word. The mask is ignored.
  - Out of range: no array write, rsp_rdata=0, rsp_err=1. The FSM flow is unchanged.
- Responder-side rules:
  - req_ready=0 in WAIT and RESP; requests presented then are not accepted.
  - Latched fields are used for the access; req_* changes after accept have no effect.
  - A store with wmask[3:0]=0 completes normally and writes nothing.
- Requester obligations: no request-side transaction is dropped or duplicated. Whether req_* may change while req_valid=1 and req_ready=0 is the requester's concern.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, cnt=0, req_ready=1 after reset.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset.
- Accept edge E0 = the rising edge with req_valid&req_ready=1.
- State is RESP (rsp_valid=1) in the cycle after edge E0+LATENCY, with rsp_rdata valid in that same cycle.
  - LATENCY=1: rsp_valid in the 2nd cycle after the request cycle.
- Response completes on the first edge with rsp_valid&rsp_ready; IDLE (req_ready=1) follows in the next cycle.
- If rsp_ready is held 1, back-to-back throughput is one transaction per LATENCY+2 cycles.
- rsp_ready=0 stalls the FSM indefinitely in RESP; outputs stay constant.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is abandoned and no array write occurs.
  - A write already performed on the WAIT→RESP edge persists.
- Load after store to the same word: the load sees the stored data. Transactions are serialised, so no hazard exists.

## Test plan
- Reset, LATENCY=2:
  - rst_n low mid-WAIT → rsp_valid=0, req_ready=1 immediately; a store in flight leaves the word unchanged.
- Full-word store then load, LATENCY=2, rsp_ready=1:
  - Store 32'hDEADBEEF to 0x8000_0010 with wmask 8'h0F.
  - Load 0x8000_0012 → rsp_rdata=32'hDEADBEEF, rsp_err=0.
  - rsp_valid appears 2 edges after each accept.
- Byte/half masks, on the word at 0x8000_0020 preset to 32'h11223344:
  - Store wdata 32'h00AA0000 with wmask 8'h04 → load returns 32'h11AA3344.
  - Store wdata 32'hBBCC0000 with wmask 8'h0C → load returns 32'hBBCC3344.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable.
  - req_valid=1 during that time is not accepted (req_ready=0).
  - Release → IDLE next cycle.
- Out of range:
  - Load 0x7FFF_FFFC → rsp_err=1, rsp_rdata=0.
  - Store to BASE_ADDR+4*DEPTH_WORDS → rsp_err=1, and a follow-up load of word DEPTH_WORDS-1 is unchanged.
- LATENCY=1 and LATENCY=15 builds:
  - Measure accept-to-rsp_valid at 1 and 15 edges respectively.
  - Back-to-back loads with rsp_ready=1 give 3 and 17 cycles per transaction respectively.
